// File: rtl/cpu_contention.sv
// cpu_contention: T-state scheduler for the Z80 core.
//
// Turns the 3.5 MHz T-state strobe into the CPU clock enable, runs the 48K
// frame counters, generates the 50 Hz maskable interrupt and holds the CPU
// off contended accesses while the video fetcher owns the bus.
//
// Ports:
//   clock   in   system clock
//   reset   in   asynchronous reset, active low
//   ce      in   T-state strobe, one clock wide
//   mreq    in   CPU MREQ_n
//   iorq    in   CPU IORQ_n
//   a       in   CPU address bus
//   cpu_ce  out  CPU clock enable (combinational, zero latency)
//   int_n   out  maskable interrupt, active low
//   hcount  out  T-state within line
//   vcount  out  line within frame
//   stall   out  high while the scheduler is in the stall state
module cpu_contention #(
  parameter int unsigned H_TSTATES  = 224,
  parameter int unsigned V_LINES    = 312,
  parameter int unsigned INT_LEN    = 32,
  parameter int unsigned DISP_FIRST = 64,
  parameter int unsigned DISP_LINES = 192,
  parameter int unsigned CONT_START = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        mreq,
  input  logic        iorq,
  input  logic [15:0] a,
  output logic        cpu_ce,
  output logic        int_n,
  output logic [8:0]  hcount,
  output logic [8:0]  vcount,
  output logic        stall
);

  localparam logic [8:0] HLast     = 9'(H_TSTATES - 1);
  localparam logic [8:0] VLast     = 9'(V_LINES - 1);
  localparam logic [8:0] IntLen    = 9'(INT_LEN);
  localparam logic [8:0] DispFirst = 9'(DISP_FIRST);
  localparam logic [8:0] DispLines = 9'(DISP_LINES);
  localparam logic [8:0] ContStart = 9'(CONT_START);
  localparam logic [8:0] ContLen   = 9'd128;

  typedef enum logic [1:0] {
    StIdle,
    StStall,
    StBusy
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] hcount_q, hcount_d;
  logic [8:0] vcount_q, vcount_d;
  logic       int_n_q, int_n_d;

  logic       cont_req;
  logic       in_win;
  logic       busy;
  logic       stall_now;
  logic [8:0] hoff;
  logic [8:0] voff;
  logic       unused_a;

  assign unused_a = ^a[13:1];

  // Contended: memory in 0x4000-0x7FFF, or any even-port I/O.
  assign cont_req = (~mreq & (a[15:14] == 2'b01)) | (~iorq & ~a[0]);

  // Offset compares avoid a constant lower-bound compare when the start is 0.
  assign hoff   = hcount_q - ContStart;
  assign voff   = vcount_q - DispFirst;
  assign in_win = (voff < DispLines) && (hoff < ContLen);
  // Video owns the bus for the first six T-states of every eight.
  assign busy   = in_win && (hoff[2:0] < 3'd6);

  // Frame counters and registered interrupt.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    int_n_d  = int_n_q;
    if (ce) begin
      int_n_d = ~((vcount_q == 9'd0) && (hcount_q < IntLen));
      if (hcount_q == HLast) begin
        hcount_d = 9'd0;
        vcount_d = (vcount_q == VLast) ? 9'd0 : vcount_q + 9'd1;
      end else begin
        hcount_d = hcount_q + 9'd1;
      end
    end
  end

  // Scheduler: stall_now is a function of the current T-state only, so a
  // line or frame wrap while stalled is re-evaluated against the new counters.
  always_comb begin
    state_d   = state_q;
    stall_now = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall_now = cont_req & busy;
        if (ce && cont_req) begin
          state_d = busy ? StStall : StBusy;
        end
      end
      StStall: begin
        stall_now = busy;
        if (ce && !busy) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Held until the bus cycle ends; one stall at most per cycle.
        if (ce && mreq && iorq) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      hcount_q <= 9'd0;
      vcount_q <= 9'd0;
      int_n_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      int_n_q  <= int_n_d;
    end
  end

  // Reset gates the enable directly so the CPU is frozen while it is held.
  assign cpu_ce = ce & reset & ~stall_now;
  assign int_n  = int_n_q;
  assign hcount = hcount_q;
  assign vcount = vcount_q;
  assign stall  = (state_q == StStall);

endmodule

// File: tb/tb_cpu_contention.sv
// tb_cpu_contention: directed self-checking bench for cpu_contention.
module tb_cpu_contention;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ce    = 1'b0;
  logic        mreq  = 1'b1;
  logic        iorq  = 1'b1;
  logic [15:0] a     = 16'h0000;
  logic        cpu_ce;
  logic        int_n;
  logic [8:0]  hcount;
  logic [8:0]  vcount;
  logic        stall;

  int checks = 0;
  int errors = 0;
  int h_m    = 0;
  int v_m    = 0;

  cpu_contention dut (
    .clock  (clock),
    .reset  (reset),
    .ce     (ce),
    .mreq   (mreq),
    .iorq   (iorq),
    .a      (a),
    .cpu_ce (cpu_ce),
    .int_n  (int_n),
    .hcount (hcount),
    .vcount (vcount),
    .stall  (stall)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One T-state: ce high across one rising edge; cpu_ce sampled mid-low-phase.
  task automatic step(output logic pass);
    @(negedge clock);
    ce = 1'b1;
    #1 pass = cpu_ce;
    @(posedge clock);
    #1 ce = 1'b0;
    if (h_m == 223) begin
      h_m = 0;
      v_m = (v_m == 311) ? 0 : v_m + 1;
    end else begin
      h_m++;
    end
  endtask

  task automatic goto_pos(input int v, input int h);
    logic p;
    mreq = 1'b1;
    iorq = 1'b1;
    while (!(v_m == v && h_m == h)) step(p);
  endtask

  // Request must already be driven; expects n stalled T-states, a granted
  // one, then a release that returns to idle.
  task automatic burst(input string tag, input int n);
    logic p;
    for (int i = 0; i < n; i++) begin
      step(p);
      check({tag, "_stall_ce"}, p, 0);
      check({tag, "_stall_flag"}, stall, 1);
    end
    step(p);
    check({tag, "_grant_ce"}, p, 1);
    check({tag, "_grant_flag"}, stall, 0);
    mreq = 1'b1;
    iorq = 1'b1;
    step(p);
    check({tag, "_release_ce"}, p, 1);
  endtask

  task automatic pass_run(input string tag, input int n);
    logic p;
    for (int i = 0; i < n; i++) begin
      step(p);
      check({tag, "_ce"}, p, 1);
      check({tag, "_flag"}, stall, 0);
    end
  endtask

  initial begin
    logic p;
    logic prev;
    int   first_fall;
    int   second_fall;
    int   lows;

    // Reset state.
    #12;
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    check("rst_int_n", int_n, 1);
    check("rst_stall", stall, 0);
    ce = 1'b1;
    #1 check("rst_cpu_ce", cpu_ce, 0);
    ce = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // Contended address outside the display lines never stalls.
    goto_pos(10, 0);
    mreq = 1'b0;
    a    = 16'h4000;
    pass_run("border", 8);
    mreq = 1'b1;

    goto_pos(64, 0);
    check("pos_hcount", hcount, 0);
    check("pos_vcount", vcount, 64);

    // p=0: six stalled T-states, then granted and held in the bus cycle.
    mreq = 1'b0;
    a    = 16'h4000;
    for (int i = 0; i < 6; i++) begin
      step(p);
      check("p0_stall_ce", p, 0);
      check("p0_stall_flag", stall, 1);
    end
    step(p);
    check("p0_grant_ce", p, 1);
    check("p0_grant_flag", stall, 0);
    pass_run("held", 4);
    mreq = 1'b1;
    step(p);
    check("held_release_ce", p, 1);

    goto_pos(64, 13);
    mreq = 1'b0;
    a    = 16'h4000;
    burst("p5", 1);

    goto_pos(64, 22);
    mreq = 1'b0;
    burst("p6", 0);

    goto_pos(64, 31);
    mreq = 1'b0;
    burst("p7", 0);

    // Uncontended memory and odd-port I/O inside the window.
    goto_pos(64, 40);
    mreq = 1'b0;
    a    = 16'h8000;
    pass_run("upper_mem", 8);
    mreq = 1'b1;
    goto_pos(64, 48);
    iorq = 1'b0;
    a    = 16'h0001;
    pass_run("odd_port", 8);
    iorq = 1'b1;

    // Even port contends like low memory.
    goto_pos(64, 56);
    iorq = 1'b0;
    a    = 16'h00FE;
    burst("even_port", 6);

    // Just past the window end no stall is applied.
    goto_pos(64, 128);
    mreq = 1'b0;
    a    = 16'h4000;
    burst("win_end", 0);

    // Reset mid-stall at p=2.
    goto_pos(65, 8);
    mreq = 1'b0;
    a    = 16'h4000;
    step(p);
    check("mid_p0_ce", p, 0);
    step(p);
    check("mid_p1_ce", p, 0);
    check("mid_flag", stall, 1);
    @(negedge clock);
    reset = 1'b0;
    ce    = 1'b1;
    #1;
    check("mid_rst_cpu_ce", cpu_ce, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_hcount", hcount, 0);
    check("mid_rst_vcount", vcount, 0);
    ce   = 1'b0;
    mreq = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b1;
    h_m   = 0;
    v_m   = 0;

    // Full frame plus two T-states: interrupt width and period.
    prev        = int_n;
    first_fall  = 0;
    second_fall = 0;
    lows        = 0;
    for (int idx = 1; idx <= 69890; idx++) begin
      step(p);
      if (idx == 1) begin
        check("post_rst_ce", p, 1);
        check("post_rst_hcount", hcount, 1);
      end
      if (prev && !int_n) begin
        if (first_fall == 0) first_fall = idx;
        else if (second_fall == 0) second_fall = idx;
      end
      if (idx <= 69888 && !int_n) lows++;
      prev = int_n;
    end
    check("int_first_fall", first_fall, 1);
    check("int_second_fall", second_fall, 69889);
    check("int_low_len", lows, 32);
    check("frame_hcount", hcount, 2);
    check("frame_vcount", vcount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
